mux_scan_serializer: RTL
========================

# mux_scan_serializer

Parallel-in, serial-out scan controller that sits directly upstream of `mux16x1`. It accepts a 16-bit word over a valid/ready handshake and holds it on the mux data inputs. It then steps the mux select through all 16 positions, one per accepted serial beat, and forwards the mux output `y` as a serial stream with its own valid/ready handshake. The mux stays purely combinational; this block adds the sequencing, holding and flow control.

## Interface
Parameters:
- `WIDTH`, 16: word width; fixed at 16 to match `mux16x1`.
- `SEL_W`, 4: select width, log2(WIDTH).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: block can accept a word.
- `in_data`  in  16: word to serialize.
- `msb_first`  in  1: bit order, sampled with `in_data`; 0 = bit 0 first, 1 = bit 15 first.
- `i`  out  16: held word; drives mux `i`.
- `s`  out  4: select; drives mux `s`.
- `y`  in  1: mux output.
- `ser_valid`  out  1: serial bit valid.
- `ser_data`  out  1: serial bit.
- `ser_last`  out  1: final bit of the word.
- `ser_ready`  in  1: downstream accepts the bit.
- `done`  out  1: one-cycle pulse after the final bit is accepted.

## Operation
States:
- IDLE
  - `in_ready`=1, `ser_valid`=0.
  - On `in_valid`&&`in_ready`: `i`<=`in_data`, latch `msb_first` into `dir`, `s`<=(`msb_first`?15:0), go to SHIFT.
- SHIFT
  - `ser_valid`=1, `ser_data`=`y` (combinational through the mux, equal to `i[s]`).
  - On `ser_ready`: `s` steps +1 (`dir`=0) or -1 (`dir`=1).
  - `ser_last`=1 when `s` is the terminal index (15 for `dir`=0, 0 for `dir`=1). The parity build changes this rule; see Configuration.
  - On the last-bit handshake: go to IDLE, pulse `done` next cycle, leave `s` at the terminal index.
- `in_ready`=0 outside IDLE; `in_valid` is ignored there.
- Without `ser_ready`: `ser_valid`, `ser_data`, `s` and `i` hold stable (no bit drop, no bit repeat).
- `s` never wraps mid-word. The terminal handshake exits SHIFT before any step past 15 or below 0.
- `i` retains the last word in IDLE; it is not cleared.
- `ser_data` drives 0 when `ser_valid`=0, so `y` is gated.

## Timing
- Reset values: `i`=0, `s`=0, state=IDLE, `in_ready`=1, `ser_valid`=0, `ser_data`=0, `ser_last`=0, `done`=0, `dir`=0.
- Reset is asynchronous at any time, including mid-word. The block returns to IDLE immediately, the partial word is discarded, and no `done` pulse occurs.
- Word accepted at edge N: first bit valid in cycle N+1.
- With `ser_ready` held high: 16 beats in cycles N+1..N+16, `ser_last` in N+16, `done` in N+17, `in_ready`=1 in N+17.
- Minimum word period is 17 cycles; no back-to-back overlap.
- `ser_ready` low for k cycles extends the word by k cycles.
- All outputs are registered except `ser_data` (mux path) and the combinational `ser_valid`/`ser_last`/`in_ready` decodes of state and `s`.

## Configuration
- `MUX_SCAN_PARITY_EN` defined:
  - After the 16th data beat, the block enters a PARITY state and emits one extra beat with `ser_data`=^`i` (even parity, XOR of all bits).
  - `ser_last` marks the parity beat only, not the 16th data beat.
  - 17 beats per word; `done` comes 18 cycles after acceptance at full rate.
  - `s` holds at the terminal index during PARITY.
- Undefined: the PARITY state is absent; 16 beats per word.

## Structure
- Package `mux_scan_pkg` holds:
  - `WIDTH`, `SEL_W` constants.
  - `state_t` enum {IDLE, SHIFT, PARITY}; PARITY is used only under the macro.
  - Terminal-index constants `SEL_FIRST_LSB`=0 and `SEL_FIRST_MSB`=15.
- One sub-module: `sel_counter`, a 4-bit up/down counter with load value, load strobe, enable and direction, async active-low reset. It provides `s` and the terminal flag.
- `mux16x1` is not instantiated inside the block. The bench and the top level connect `i`/`s`/`y` to it.

## Test plan
- Reset then idle: after `rst_n` release, `in_ready`=1, `s`=0, `ser_valid`=0; `in_valid`=0 for 10 cycles -> no state change.
- LSB-first full rate:
  - Stimulus: `in_data`=16'h5352, `msb_first`=0, `ser_ready`=1.
  - Response: serial bits 0,1,0,0,1,0,1,0,1,1,0,0,1,0,1,0; `ser_last` on beat 16; `done` at acceptance+17.
- MSB-first with backpressure:
  - Stimulus: `in_data`=16'h95E8, `msb_first`=1, `ser_ready` low on alternate cycles.
  - Response: bits 1,0,0,1,0,1,0,1,1,1,1,0,1,0,0,0; `s` counts 15->0; no bit duplicated or lost; word completes in 32 cycles.
- Busy ignore: a second `in_valid` with 16'hFFFF during SHIFT of 16'h0000 -> not accepted, all 16 bits 0, `i` stays 16'h0000.
- Reset mid-word: `rst_n` low after beat 5 of 16'hA5A5 -> `ser_valid`=0 asynchronously, no `done`; the next word 16'h0001 serializes correctly from bit 0.
- Parity build (`MUX_SCAN_PARITY_EN`):
  - 16'h0007, LSB-first -> 17 beats, beat 17 = 1, `ser_last` only on beat 17.
  - 16'h0003 -> beat 17 = 0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan serializer.
package mux_scan_pkg;

    localparam int WIDTH = 16;
    localparam int SEL_W = 4;

    localparam logic [3:0] SEL_FIRST_LSB = 4'd0;
    localparam logic [3:0] SEL_FIRST_MSB = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Even parity over a full word.
    function automatic logic even_parity(input logic [15:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sel_counter.sv
// 4-bit up/down select counter with load and terminal-index flag.
module sel_counter
    import mux_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       dir,
    output logic [3:0] cnt,
    output logic       term
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Load wins over stepping; dir=1 counts down.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = dir ? (cnt_q - 4'd1) : (cnt_q + 4'd1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= SEL_FIRST_LSB;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = dir ? (cnt_q == SEL_FIRST_LSB) : (cnt_q == SEL_FIRST_MSB);

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-in serial-out scan controller driving an external mux16x1.
// Optional trailing even-parity beat when MUX_SCAN_PARITY_EN is defined.
module mux_scan_serializer #(
    parameter int WIDTH = mux_scan_pkg::WIDTH,
    parameter int SEL_W = mux_scan_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    output logic [WIDTH-1:0] i,
    output logic [SEL_W-1:0] s,
    input  logic             y,
    output logic             ser_valid,
    output logic             ser_data,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             done
);
    import mux_scan_pkg::*;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    logic             cnt_load_s;
    logic [3:0]       cnt_load_val_s;
    logic             cnt_en_s;
    logic             term_s;
    logic             in_ready_s;
    logic             ser_valid_s;
    logic             ser_data_s;
    logic             ser_last_s;

    sel_counter u_sel_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .en       (cnt_en_s),
        .dir      (dir_q),
        .cnt      (s),
        .term     (term_s)
    );

    // Next-state, handshake decode and serial data steering.
    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        dir_d          = dir_q;
        done_d         = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = SEL_FIRST_LSB;
        cnt_en_s       = 1'b0;
        in_ready_s     = 1'b0;
        ser_valid_s    = 1'b0;
        ser_data_s     = 1'b0;
        ser_last_s     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    i_d            = in_data;
                    dir_d          = msb_first;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = msb_first ? SEL_FIRST_MSB : SEL_FIRST_LSB;
                    state_d        = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                ser_valid_s = 1'b1;
                ser_data_s  = y;
`ifdef MUX_SCAN_PARITY_EN
                ser_last_s  = 1'b0;
`else
                ser_last_s  = term_s;
`endif
                // The terminal beat leaves SHIFT instead of stepping, so s never wraps.
                if (ser_ready) begin
                    if (term_s) begin
`ifdef MUX_SCAN_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_en_s = 1'b1;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            PARITY: begin
`ifdef MUX_SCAN_PARITY_EN
                ser_valid_s = 1'b1;
                ser_data_s  = even_parity(i_q);
                ser_last_s  = 1'b1;
                if (ser_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = PARITY;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and held-word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign i         = i_q;
    assign done      = done_q;
    assign in_ready  = in_ready_s;
    assign ser_valid = ser_valid_s;
    assign ser_data  = ser_data_s;
    assign ser_last  = ser_last_s;

endmodule
